uart_byte_fifo: RTL and testbench
=================================

# uart_byte_fifo

Byte FIFO between the UART receiver and the UART transmitter in the echo path. It captures each byte from `uart_rx` on its one-cycle `ready` strobe and stores it. It forwards stored bytes in order to `uart_tx` using one-cycle `write` strobes paced by `busy`, so back-to-back received bytes are never lost while the transmitter is still shifting.

## Interface
- `DEPTH`, default 16: number of byte entries; a power of two, ≥ 2.
- `clk`  input  1: system clock (CLOCK_50 at top level).
- `resetn`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: one-cycle push strobe (from `uart_rx` `ready`).
- `in_data`  input  8: byte to push; sampled when `in_valid`=1.
- `tx_write`  output  1: one-cycle write strobe to `uart_tx`.
- `tx_data`  output  8: byte for `uart_tx`; valid in the `tx_write` cycle and held until the next strobe.
- `tx_busy`  input  1: `uart_tx` busy flag.
- `count`  output  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `empty`  output  1: `count`==0.
- `full`  output  1: `count`==DEPTH.
- `overflow`  output  1: sticky dropped-byte flag (see Configuration).
- `clear_overflow`  input  1: clears `overflow`.

## Operation
- Storage: DEPTH×8 array, write pointer and read pointer each $clog2(DEPTH) bits, wrapping modulo DEPTH. `count` is a separate register.
- Push: on a rising edge with `in_valid`=1:
  - If not full, or a pop occurs on the same edge: write `in_data` at the write pointer and advance it.
  - If full and no pop on that edge: drop the byte; pointers and count are unchanged.
- Pop: happens on the edge where the FSM leaves IDLE for STROBE. That edge loads `tx_data` from the read pointer and advances the read pointer.
- Simultaneous push and pop: both take effect and `count` is unchanged. This also applies when the FIFO is full.
- FSM, all outputs registered:
  - IDLE: if `count`≠0 and `tx_busy`=0, pop and go to STROBE. Otherwise stay.
  - STROBE: `tx_write`=1 for exactly this cycle, then go to GUARD.
  - GUARD: ignore `tx_busy` for one cycle so the transmitter can raise it, then go to DRAIN.
  - DRAIN: wait until `tx_busy`=0, then go to IDLE.
- `tx_write` is high only in STROBE.
- `in_valid` held high for several cycles pushes once per cycle.
- `in_data` is not sampled when `in_valid`=0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM in IDLE, pointers 0, `count`=0.
  - `empty`=1, `full`=0, `tx_write`=0, `tx_data`=8'h00, `overflow`=0.
  - Array contents are don't-care.
- Latency with an empty FIFO and `tx_busy`=0: `in_valid` in cycle 0 gives `count`=1 in cycle 1 and `tx_write`=1 in cycle 2.
- Minimum spacing between `tx_write` strobes is 4 cycles: STROBE, GUARD, DRAIN, IDLE.
- `count`, `empty` and `full` update on the edge after the push or pop.
- If reset asserts mid-frame, the FSM returns to IDLE immediately and `tx_write` drops in the same instant. Queued bytes are discarded.
- If `tx_busy`=1 while in IDLE, no pop occurs, even with data queued.

## Configuration
- Macro: `UART_BYTE_FIFO_OVERFLOW_EN`.
- Defined:
  - `overflow` sets on any dropped push.
  - It stays set until `clear_overflow`=1 on a rising edge.
  - If a drop and `clear_overflow` occur on the same edge, the result is `overflow`=1 (set wins).
- Undefined:
  - `overflow` is tied to 0 and `clear_overflow` is ignored.
  - Drop behaviour is unchanged.

## Test plan
- Single byte: push 8'hA5 with `tx_busy`=0 -> `tx_write` pulses once 2 cycles later with `tx_data`=8'hA5. Then `empty`=1 and `count`=0.
- Ordering under back-pressure: hold `tx_busy`=1 and push 8'h01, 8'h02, 8'h03 -> `count`=3 and no `tx_write`. Release `tx_busy` -> strobes carry 01, 02, 03 in order, one strobe per `busy` low period.
- Full and drop (DEPTH=4, macro defined): push 5 bytes with `tx_busy`=1 -> `full`=1 and `count`=4. The 5th byte is absent from the output stream and `overflow`=1. `clear_overflow` returns it to 0.
- Simultaneous push/pop at full (DEPTH=4): push on the pop edge -> `count` stays 4 and the new byte is delivered last.
- Wrap-around (DEPTH=4): stream 10 bytes 8'h10..8'h19 with a transmitter model -> all 10 arrive in order and the pointers wrap twice.
- Reset mid-operation: assert `resetn`=0 during DRAIN with 2 bytes queued -> all outputs return to their reset values immediately, and no further `tx_write` occurs after release.

Source files
------------

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx in the echo path, with a small pacing FSM.
// Optional sticky drop flag is enabled by defining UART_BYTE_FIFO_OVERFLOW_EN.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   tx_write,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    input  logic                   clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STROBE, GUARD, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_write_q, tx_write_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [7:0]    mem_q [DEPTH];
    logic          pop, push, drop;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = STROBE;
                end
            end
            STROBE: state_d = GUARD;
            // busy is ignored here so the transmitter has a cycle to raise it
            GUARD:  state_d = DRAIN;
            DRAIN:  if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // a pop on the same edge frees a slot, so a full FIFO still accepts
        push = in_valid && (count_q != FULL_CNT || pop);
        drop = in_valid && !push;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        tx_write_d = pop;
        tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
        empty_d    = (count_d == '0);
        full_d     = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_write_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_write_q <= tx_write_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef UART_BYTE_FIFO_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (drop)                overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) overflow_q <= 1'b0;
        else         overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`else
    logic unused_ovf;
    assign unused_ovf = clear_overflow | drop;
    assign overflow   = 1'b0;
`endif

    assign tx_write = tx_write_q;
    assign tx_data  = tx_data_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo (DEPTH=4) with a queue-based reference model
// checked every cycle, plus hand-computed checks on the delivered byte stream.
module tb_uart_byte_fifo;

    localparam int DEPTH = 4;
`ifdef UART_BYTE_FIFO_OVERFLOW_EN
    localparam int OVF_EN = 1;
`else
    localparam int OVF_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clear_overflow = 1'b0;
    logic       busy_dir = 1'b0;
    logic       txm_en = 1'b0;
    logic       txm_busy = 1'b0;
    logic       tx_busy;
    logic       tx_write;
    logic [7:0] tx_data;
    logic [2:0] count;
    logic       empty, full, overflow;

    int n_chk = 0;
    int n_fail = 0;

    assign tx_busy = txm_en ? txm_busy : busy_dir;

    uart_byte_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .tx_write(tx_write), .tx_data(tx_data), .tx_busy(tx_busy),
        .count(count), .empty(empty), .full(full), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transmitter stand-in: busy for three cycles after each strobe.
    int txm_cnt = 0;
    always @(posedge clk) begin
        if (tx_write)         txm_cnt = 3;
        else if (txm_cnt > 0) txm_cnt--;
        #1 txm_busy = (txm_cnt > 0);
    end

    // Reference model: byte queue plus "edges since last strobe" pacing rule.
    logic [7:0] mq[$];
    bit         m_ready = 1'b1;
    int         m_k = 0;
    bit         m_wr = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            m_ready = 1'b1;
            m_k     = 0;
            m_wr    = 1'b0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            bit dropped;
            dropped = 1'b0;
            m_wr = 1'b0;
            if (m_ready) begin
                if (mq.size() > 0 && !tx_busy) begin
                    m_data  = mq.pop_front();
                    m_wr    = 1'b1;
                    m_ready = 1'b0;
                    m_k     = 0;
                end
            end else begin
                m_k++;
                if (m_k >= 3 && !tx_busy) m_ready = 1'b1;
            end
            if (in_valid) begin
                if (mq.size() < DEPTH) mq.push_back(in_data);
                else dropped = 1'b1;
            end
            if (OVF_EN != 0) begin
                if (dropped)             m_ovf = 1'b1;
                else if (clear_overflow) m_ovf = 1'b0;
            end
        end
    end

    logic [7:0] got[$];
    always @(negedge clk) begin
        check("tx_write", int'(tx_write), int'(m_wr));
        check("tx_data",  int'(tx_data),  int'(m_data));
        check("count",    int'(count),    mq.size());
        check("empty",    int'(empty),    int'(mq.size() == 0));
        check("full",     int'(full),     int'(mq.size() == DEPTH));
        check("overflow", int'(overflow), int'(m_ovf));
        if (resetn && tx_write) got.push_back(tx_data);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 200 && got.size() < n; i++) step(1);
        check("got_size", got.size(), n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_write"}, int'(tx_write), 0);
        check({tag, "_tx_data"},  int'(tx_data),  0);
        check({tag, "_count"},    int'(count),    0);
        check({tag, "_empty"},    int'(empty),    1);
        check({tag, "_full"},     int'(full),     0);
        check({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        #1 resetn = 1'b0;
        #12 check_reset_vals("rst");
        step(1);
        resetn = 1'b1;
        step(2);

        // single byte: strobe two cycles after the push
        in_valid = 1'b1; in_data = 8'hA5;
        step(1);
        in_valid = 1'b0;
        check("single_count1", int'(count), 1);
        check("single_nowr", int'(tx_write), 0);
        step(1);
        check("single_wr", int'(tx_write), 1);
        check("single_data", int'(tx_data), 8'hA5);
        step(1);
        check("single_wr_drop", int'(tx_write), 0);
        check("single_empty", int'(empty), 1);
        check("single_count0", int'(count), 0);
        step(4);

        // ordering under back-pressure
        got.delete();
        busy_dir = 1'b1;
        push(8'h01); push(8'h02); push(8'h03);
        step(5);
        check("bp_count", int'(count), 3);
        check("bp_nowr", got.size(), 0);
        txm_en = 1'b1; busy_dir = 1'b0;
        wait_got(3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("bp_order", int'(got[i]), i + 1);
        step(10);

        // full and drop
        txm_en = 1'b0; busy_dir = 1'b1;
        got.delete();
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        step(1);
        check("drop_full", int'(full), 1);
        check("drop_count", int'(count), 4);
        check("drop_ovf", int'(overflow), OVF_EN);
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        check("drop_ovf_clr", int'(overflow), 0);
        txm_en = 1'b1; busy_dir = 1'b0;
        wait_got(4);
        step(12);
        check("drop_absent", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("drop_order", int'(got[i]), 8'h11 + i);

        // simultaneous push and pop while full
        txm_en = 1'b0; busy_dir = 1'b1;
        got.delete();
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
        step(2);
        check("sim_full", int'(full), 1);
        txm_en = 1'b1; busy_dir = 1'b0;
        in_valid = 1'b1; in_data = 8'h25;
        step(1);
        in_valid = 1'b0;
        check("sim_count", int'(count), 4);
        check("sim_wr", int'(tx_write), 1);
        check("sim_data", int'(tx_data), 8'h21);
        wait_got(5);
        if (got.size() == 5) check("sim_last", int'(got[4]), 8'h25);
        step(10);

        // wrap-around: ten bytes through a four-entry FIFO
        got.delete();
        for (int i = 0; i < 10; i++) begin
            push(8'h10 + 8'(i));
            step(5);
        end
        wait_got(10);
        for (int i = 0; i < 10 && i < got.size(); i++) check("wrap_order", int'(got[i]), 8'h10 + i);
        step(10);

        // reset during DRAIN with two bytes queued
        txm_en = 1'b0; busy_dir = 1'b0;
        got.delete();
        push(8'h31);
        push(8'h32);
        busy_dir = 1'b1;
        push(8'h33);
        step(2);
        check("mid_count", int'(count), 2);
        check("mid_got", got.size(), 1);
        #3 resetn = 1'b0;
        #1 check_reset_vals("mid_rst");
        step(2);
        resetn = 1'b1;
        busy_dir = 1'b0;
        step(10);
        check("post_rst_nowr", got.size(), 1);
        check("post_rst_empty", int'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
